// File: rtl/ztex_host_if_pkg.sv
// Shared types and helpers for the multi-core EZ-USB host interface.
// No logic of its own; snapshot size depends on HOST_IF_CRC_EN.
// Holds the snapshot layout, the CRC-8 step and the round-robin pick.
package ztex_host_if_pkg;

    localparam int ST_OVF    = 7;
    localparam int ST_NEMPTY = 6;
    localparam int ST_FILL_W = 6;

    localparam int SNAP_BASE_BYTES = 9;
`ifdef HOST_IF_CRC_EN
    localparam int SNAP_BYTES = 10;
`else
    localparam int SNAP_BYTES = 9;
`endif

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam int         RR_MAX   = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_SHIFT
    } snap_state_t;

    // First requester at or after ptr (wrapping at n), or -1 when nothing is pending.
    function automatic int rr_grant(input logic [RR_MAX-1:0] req, input int n, input int ptr);
        int idx;
        rr_grant = -1;
        for (int k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (rr_grant < 0 && req[idx[4:0]]) rr_grant = idx;
            end
        end
    endfunction

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/host_strobe_sync.sv
// Synchronises an asynchronous host strobe and flags each filtered level change.
// Latency: two clk cycles from strobe edge to tgl; no backpressure (host-paced).
// Chain is seeded with the live level on the first clk after reset release.
module host_strobe_sync #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic lvl,
    output logic tgl
);

    logic          in_q;
    logic          seeded;
    logic [FILT:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q   <= 1'b0;
            chain  <= '0;
            seeded <= 1'b0;
        end else if (!seeded) begin
            in_q   <= strobe;
            chain  <= {(FILT+1){strobe}};
            seeded <= 1'b1;
        end else begin
            in_q  <= strobe;
            chain <= {chain[FILT-1:0], in_q};
        end
    end

    assign lvl = chain[0];
    // Newest sample must differ from FILT older samples that all agree.
    assign tgl = (chain[0] != chain[1]) && ((&chain[FILT:1]) || !(|chain[FILT:1]));

endmodule

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with head peek and fill count; DEPTH power of two.
// Latency: pushed data visible at head one cycle later.
// Backpressure: push while full and pop while empty are ignored; caller watches full/empty.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_vld,
    output logic [W-1:0]             head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = count[AW];
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ztex_host_if_mc.sv
// Byte-serial EZ-USB host interface: work-frame deserialiser plus golden-nonce FIFO snapshot reader.
// Latency: work_data two cycles after the last rd toggle is seen; write one cycle after outbuf.
// No backpressure to host (strobe paced); full FIFO drops and flags overflow. HOST_IF_CRC_EN appends CRC-8.
module ztex_host_if_mc
    import ztex_host_if_pkg::*;
#(
    parameter int IN_BYTES     = 84,
    parameter int NUM_CORES    = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int FILT         = 3,
    parameter int IDLE_TIMEOUT = 4096,
    parameter int LOAD_HOLD    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rd_clk,
    input  logic [7:0]                read,
    input  logic                      wr_clk,
    input  logic                      wr_start,
    output logic [7:0]                write,
    output logic [8*IN_BYTES-1:0]     work_data,
    output logic                      new_work,
    input  logic [NUM_CORES-1:0]      core_match,
    input  logic [32*NUM_CORES-1:0]   core_nonce,
    input  logic [31:0]               cur_nonce
);

    localparam int IW = 8*IN_BYTES;
    localparam int BW = $clog2(IN_BYTES);
    localparam int TW = $clog2(IDLE_TIMEOUT+1);
    localparam int HW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = 8*SNAP_BYTES;

    localparam logic [BW-1:0] LAST_BYTE = BW'(IN_BYTES-1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(IDLE_TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LOAD_HOLD-1);
    localparam logic [CW-1:0] LAST_CORE = CW'(NUM_CORES-1);

    // ---------------- host strobe synchronisers ----------------
    logic rd_lvl, rd_tgl, wr_lvl, wr_tgl, ws_lvl, ws_tgl;
    logic ws_prev, start_act;
    logic sync_unused;

    host_strobe_sync #(.FILT(FILT)) u_rd_sync (
        .clk(clk), .reset(reset), .strobe(rd_clk), .lvl(rd_lvl), .tgl(rd_tgl)
    );
    host_strobe_sync #(.FILT(FILT)) u_wr_sync (
        .clk(clk), .reset(reset), .strobe(wr_clk), .lvl(wr_lvl), .tgl(wr_tgl)
    );
    host_strobe_sync #(.FILT(FILT)) u_ws_sync (
        .clk(clk), .reset(reset), .strobe(wr_start), .lvl(ws_lvl), .tgl(ws_tgl)
    );

    assign sync_unused = rd_lvl ^ wr_lvl ^ ws_tgl;
    assign start_act   = ws_lvl && ws_prev;

    // ---------------- input frame path ----------------
    logic [7:0]    read_q, read_d;
    logic [IW-1:0] shreg;
    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] idle_cnt;
    logic          frame_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_q     <= '0;
            read_d     <= '0;
            shreg      <= '0;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
            work_data  <= '0;
            new_work   <= 1'b0;
            ws_prev    <= 1'b0;
        end else begin
            // read_d lines up with the strobe sample that raises rd_tgl
            read_q     <= read;
            read_d     <= read_q;
            ws_prev    <= ws_lvl;
            new_work   <= frame_done;
            frame_done <= 1'b0;
            if (frame_done) work_data <= shreg;
            if (rd_tgl) begin
                shreg    <= {read_d, shreg[IW-1:8]};
                idle_cnt <= '0;
                if (byte_cnt == LAST_BYTE) begin
                    byte_cnt   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (idle_cnt == IDLE_MAX) begin
                byte_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // ---------------- golden nonce collection ----------------
    logic [NUM_CORES-1:0] pend_vld;
    logic [31:0]          pend_nonce [NUM_CORES];
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        gidx;
    logic [RR_MAX-1:0]    req_ext;
    logic [NUM_CORES-1:0] drain_vec;
    logic                 push_vld;
    logic [31:0]          push_dat;
    logic                 pop_vld;
    logic                 ovf, ovf_set;
    logic [31:0]          fifo_head;
    logic                 fifo_empty, fifo_full;
    logic [AW:0]          fifo_count;
    int                   gnt;

    always_comb begin
        req_ext = '0;
        req_ext[NUM_CORES-1:0] = pend_vld;
        gnt      = rr_grant(req_ext, NUM_CORES, int'(rr_ptr));
        push_vld = (gnt >= 0);
        gidx     = gnt[CW-1:0];
        push_dat = pend_nonce[gidx];
        for (int i = 0; i < NUM_CORES; i++) begin
            drain_vec[i] = push_vld && (gidx == CW'(i));
        end
        // Overwriting a pending nonce that is not leaving this cycle loses it
        ovf_set = (|(core_match & pend_vld & ~drain_vec)) || (push_vld && fifo_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld <= '0;
            for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= '0;
            rr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_match[i]) begin
                    pend_vld[i]   <= 1'b1;
                    pend_nonce[i] <= core_nonce[32*i +: 32];
                end else if (drain_vec[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
            if (push_vld) rr_ptr <= (gidx == LAST_CORE) ? '0 : gidx + 1'b1;
            if (ovf_set)      ovf <= 1'b1;
            else if (pop_vld) ovf <= 1'b0;
        end
    end

    sync_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset),
        .push_vld(push_vld), .push_dat(push_dat),
        .pop_vld(pop_vld), .head_dat(fifo_head),
        .empty(fifo_empty), .full(fifo_full), .count(fifo_count)
    );

    // ---------------- snapshot build ----------------
    logic [7:0]   status;
    logic [31:0]  head;
    logic [31:0]  cnt32;
    logic [8*SNAP_BASE_BYTES-1:0] snap_base;
    logic [SW-1:0] snap;
`ifdef HOST_IF_CRC_EN
    logic [7:0]   crc;
`endif

    always_comb begin
        cnt32  = 32'(fifo_count);
        status = '0;
        status[ST_OVF]    = ovf;
        status[ST_NEMPTY] = !fifo_empty;
        status[ST_FILL_W-1:0] = (cnt32 > 32'd63) ? 6'd63 : cnt32[5:0];
        head      = fifo_empty ? 32'h0 : fifo_head;
        snap_base = {head, cur_nonce, status};
`ifdef HOST_IF_CRC_EN
        crc = 8'h00;
        for (int b = 0; b < SNAP_BASE_BYTES; b++) begin
            crc = crc8_update(crc, snap_base[8*b +: 8]);
        end
        snap = {crc, snap_base};
`else
        snap = snap_base;
`endif
    end

    // ---------------- snapshot read FSM ----------------
    snap_state_t   state;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] outbuf;
    logic          hold_last;

    assign hold_last = (hold_cnt == HOLD_LAST);
    assign pop_vld   = (state == S_HOLD) && !start_act && hold_last && !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            outbuf   <= '0;
            write    <= '0;
        end else begin
            write <= outbuf[7:0];
            if (start_act) begin
                state  <= S_LOAD;
                outbuf <= snap;
            end else begin
                case (state)
                    S_LOAD: begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                    end
                    S_HOLD: begin
                        outbuf <= snap;
                        if (hold_last) state    <= S_SHIFT;
                        else           hold_cnt <= hold_cnt + 1'b1;
                    end
                    S_SHIFT: begin
                        if (wr_tgl) outbuf <= {8'h00, outbuf[SW-1:8]};
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
